// File: rtl/map_update_ctrl_pkg.sv
// Shared types and constants for the maze map update controller and the tile decoder.
package map_update_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A_ACK,
    D_WAIT,
    D_ACK,
    COMMIT
  } state_t;

  localparam int NUM_CELLS_DEF = 20;
  localparam int MAP_W_DEF     = 8 * (NUM_CELLS_DEF + 1);

  localparam int ROBOT_IDX      = 0;
  localparam int FIRST_CELL_IDX = 1;

  localparam logic [7:0] ROBOT_DEFAULT       = 8'h13;
  localparam logic [7:0] CELL_DEFAULT_CORNER = 8'h3F;
  localparam logic [7:0] CELL_DEFAULT        = 8'h0F;

  // Every fourth cell starts walled on all sides; the rest start with two walls.
  function automatic logic [7:0] default_byte(input int idx);
    if (idx == ROBOT_IDX) return ROBOT_DEFAULT;
    return ((idx % 4) == 0) ? CELL_DEFAULT_CORNER : CELL_DEFAULT;
  endfunction

  function automatic logic [MAP_W_DEF-1:0] default_map_fn();
    logic [MAP_W_DEF-1:0] m;
    m = '0;
    for (int k = ROBOT_IDX; k <= NUM_CELLS_DEF; k++) begin
      m[MAP_W_DEF-1-8*k -: 8] = default_byte(k);
    end
    return m;
  endfunction

  localparam logic [MAP_W_DEF-1:0] DEFAULT_MAP = default_map_fn();

endpackage

// File: rtl/map_update_ctrl_sync_2ff.sv
// Two-flop synchronizer for the MCU request line.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/map_update_ctrl.sv
// Map update controller: receives address/data packets from the radio MCU and swaps them into the live map during blanking.
// Optional packet timeout in D_WAIT is built when MAP_UPDATE_TIMEOUT_EN is defined.
module map_update_ctrl
  import map_update_ctrl_pkg::*;
#(
  parameter int NUM_CELLS      = NUM_CELLS_DEF,
  parameter int MAP_W          = 8 * (NUM_CELLS + 1),
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             REQ_IN,
  input  logic [7:0]       DATA_IN,
  input  logic             V_BLANK,
  output logic             ACK_OUT,
  output logic [MAP_W-1:0] MAP,
  output logic             UPDATE_PENDING,
  output logic             FRAME_SWAP,
  output logic [7:0]       ERR_COUNT
);

  function automatic logic [MAP_W-1:0] build_map();
    logic [MAP_W-1:0] m;
    m = '0;
    m[MAP_W-1 -: 8] = default_byte(ROBOT_IDX);
    for (int k = FIRST_CELL_IDX; k <= NUM_CELLS; k++) begin
      m[MAP_W-1-8*k -: 8] = default_byte(k);
    end
    return m;
  endfunction

  localparam logic [MAP_W-1:0] DEF_MAP   = build_map();
  localparam logic [7:0]       LAST_CELL = 8'(NUM_CELLS);

  state_t           state;
  logic             req_s;
  logic [7:0]       addr;
  logic [7:0]       data;
  logic [MAP_W-1:0] shadow;
  logic             swap_now;
  logic             commit_ok;
  logic             commit_bad;
  logic             tmo_hit;

  sync_2ff u_sync (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .d     (REQ_IN),
    .q     (req_s)
  );

  assign swap_now   = V_BLANK && UPDATE_PENDING;
  assign commit_ok  = (state == COMMIT) && (addr <= LAST_CELL);
  assign commit_bad = (state == COMMIT) && (addr > LAST_CELL);

`ifdef MAP_UPDATE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == D_WAIT) && !req_s && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_cnt <= '0;
    end else if (state != D_WAIT) begin
      tmo_cnt <= '0;
    end else if (!req_s) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      ACK_OUT <= 1'b0;
      addr    <= 8'h00;
      data    <= 8'h00;
    end else begin
      case (state)
        IDLE: if (req_s) begin
          addr    <= DATA_IN;
          state   <= A_ACK;
          ACK_OUT <= 1'b1;
        end
        A_ACK: if (!req_s) begin
          state   <= D_WAIT;
          ACK_OUT <= 1'b0;
        end
        D_WAIT: begin
          if (req_s) begin
            data    <= DATA_IN;
            state   <= D_ACK;
            ACK_OUT <= 1'b1;
          end else if (tmo_hit) begin
            state <= IDLE;
          end
        end
        D_ACK: if (!req_s) begin
          state   <= COMMIT;
          ACK_OUT <= 1'b0;
        end
        COMMIT: state <= IDLE;
        default: begin
          state   <= IDLE;
          ACK_OUT <= 1'b0;
        end
      endcase
    end
  end

  // A swap coinciding with a commit takes the old shadow, so pending must stay set for the new byte.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow         <= DEF_MAP;
      MAP            <= DEF_MAP;
      UPDATE_PENDING <= 1'b0;
      FRAME_SWAP     <= 1'b0;
      ERR_COUNT      <= 8'h00;
    end else begin
      FRAME_SWAP <= swap_now;
      if (swap_now) MAP <= shadow;
      if (commit_ok) begin
        for (int k = 0; k <= NUM_CELLS; k++) begin
          if (addr == k[7:0]) shadow[MAP_W-1-8*k -: 8] <= data;
        end
      end
      if (commit_ok) UPDATE_PENDING <= 1'b1;
      else if (swap_now) UPDATE_PENDING <= 1'b0;
      if ((commit_bad || tmo_hit) && (ERR_COUNT != 8'hFF)) ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

endmodule
